sequenciador_caminho_host: RTL and testbench
============================================

# sequenciador_caminho_host

Host-side sequencer for the path-planning core. It loads obstacle writes into the planner and starts a search with a source/destination pair. It then collects the path nodes that the planner streams back from destination to source, buffers them, and replays them to the host over a valid/ready stream with a last flag. It sits between the host command interface and the planner top's obstacle, start and path-readout ports.

## Interface
Parameters:
- ADDR_WIDTH, `ADDR_WIDTH (from defines.vh), node address width
- MAX_CAMINHO, 64, path buffer depth in nodes
- TIMEOUT_CICLOS, 4096, maximum idle cycles between path strobes during collection

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid_in  in  1  host command valid
- cmd_ready_out  out  1  command accepted when both valid and ready are high
- cmd_tipo_in  in  1  0 = obstacle write, 1 = start search
- cmd_addr_a_in  in  ADDR_WIDTH  obstacle address (tipo 0) or source (tipo 1)
- cmd_addr_b_in  in  ADDR_WIDTH  destination (tipo 1 only)
- cmd_obst_in  in  1  obstacle bit (tipo 0 only)
- obstaculos_wr_enable_out  out  1  obstacle write strobe to planner
- obstaculos_wr_addr_out  out  ADDR_WIDTH  obstacle write address
- obstaculos_wr_data_out  out  1  obstacle write data
- top_wr_fonte_out  out  1  one-cycle start pulse to planner
- top_addr_fonte_out  out  ADDR_WIDTH  latched source, held until the next start
- top_addr_destino_out  out  ADDR_WIDTH  latched destination, held until the next start
- gma_read_data_in  in  ADDR_WIDTH  path node from planner
- gma_pronto_in  in  1  one-cycle strobe qualifying gma_read_data_in
- caminho_valid_out  out  1  path node valid
- caminho_ready_in  in  1  host ready for path node
- caminho_data_out  out  ADDR_WIDTH  path node
- caminho_last_out  out  1  marks the final node of the path
- ocupado_out  out  1  high in every state except OCIOSO
- erro_out  out  2  01 = timeout, 10 = overflow, 00 = ok; sticky

## Operation
- States: OCIOSO, INICIAR, COLETAR, ENVIAR, ERRO.
- OCIOSO:
  - cmd_ready_out = 1.
  - tipo 0 accepted: register addr/data and pulse obstaculos_wr_enable_out for one cycle. Back-to-back writes run at 1 per cycle.
  - tipo 1 accepted: latch the source and destination, clear erro_out, go to INICIAR.
- INICIAR: top_wr_fonte_out = 1 for exactly one cycle; clear the node count and timer; go to COLETAR.
- COLETAR:
  - Each gma_pronto_in strobe stores gma_read_data_in at buffer[count], increments count and clears the timer.
  - If the stored node equals the latched source, go to ENVIAR.
  - If a strobe fills the buffer (count reaches MAX_CAMINHO) and the node is not the source, go to ERRO with code 10.
  - If the timer reaches TIMEOUT_CICLOS, go to ERRO with code 01.
- ENVIAR:
  - Emit count nodes in the order set by Configuration. The output register advances on each valid&ready.
  - caminho_last_out is high with the final node.
  - After the last handshake, go to OCIOSO.
- ERRO: erro_out is set; go to OCIOSO next cycle. erro_out holds until the next start command is accepted.
- Node count width is $clog2(MAX_CAMINHO+1). The timer saturates and does not wrap.
- Source equal to destination: the first strobe matches, giving a path of length 1 with last set on that node.
- gma_pronto_in outside COLETAR is ignored.
- cmd_ready_out = 0 in all states except OCIOSO, so commands are never accepted mid-search.
- Asynchronous reset at any point returns to OCIOSO and discards buffer contents and any partially sent path.

## Timing
- Reset values:
  - cmd_ready_out = 1.
  - obstaculos_wr_enable_out, top_wr_fonte_out, caminho_valid_out, caminho_last_out and ocupado_out = 0.
  - All address/data outputs = 0; erro_out = 00.
- Obstacle command accepted in cycle N: write strobe in N+1.
- Start command accepted in cycle N:
  - top_wr_fonte_out and the new top_addr_* are valid in N+1.
  - COLETAR begins in N+2.
- Matching strobe in cycle M: caminho_valid_out is high in M+1 with the first node.
- Handshake: caminho_data_out and caminho_last_out stay stable while valid is high and ready is low. The next node appears the cycle after a handshake; one node per cycle with ready held high.
- Timeout: ERRO is entered when the timer reaches TIMEOUT_CICLOS cycles without a strobe; erro_out is visible the next cycle.

## Configuration
- CAMINHO_REVERSO_EN defined: ENVIAR reads buffer[count-1] down to buffer[0], so the host receives nodes from source to destination.
- Not defined: ENVIAR reads buffer[0] up to buffer[count-1], so the host receives nodes from destination to source.
- Handshake, last flag and latency are identical in both builds.

## Test plan
- Obstacle writes (5,1), (6,1), (7,0) sent back to back → three consecutive obstaculos_wr_enable_out pulses with matching addr/data one cycle after each accept.
- Start source=3, destination=9; planner strobes 9, 8, 3 → macro off: host receives 9, 8, 3 with last on 3; macro on: receives 3, 8, 9 with last on 9; erro_out = 00.
- Start source=destination=4; single strobe 4 → exactly one node, 4, with last set; FSM returns to OCIOSO.
- Host holds caminho_ready_in low for 10 cycles mid-path → data and last stable, no node lost or duplicated.
- No strobe after start for TIMEOUT_CICLOS cycles → erro_out = 01, ocupado_out drops, no path emitted. Next start clears erro_out.
- MAX_CAMINHO=4 with strobes 10, 11, 12, 13 (source 0) → erro_out = 10, no path emitted. Reset asserted mid-ENVIAR → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/sequenciador_caminho_host.sv
// Host-side sequencer: obstacle loads, search start, path collection and replay.
// Define CAMINHO_REVERSO_EN to replay the path source-first instead of destination-first.
module sequenciador_caminho_host #(
  parameter int ADDR_WIDTH     = 8,
  parameter int MAX_CAMINHO    = 64,
  parameter int TIMEOUT_CICLOS = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid_in,
  output logic                  cmd_ready_out,
  input  logic                  cmd_tipo_in,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_a_in,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_b_in,
  input  logic                  cmd_obst_in,
  output logic                  obstaculos_wr_enable_out,
  output logic [ADDR_WIDTH-1:0] obstaculos_wr_addr_out,
  output logic                  obstaculos_wr_data_out,
  output logic                  top_wr_fonte_out,
  output logic [ADDR_WIDTH-1:0] top_addr_fonte_out,
  output logic [ADDR_WIDTH-1:0] top_addr_destino_out,
  input  logic [ADDR_WIDTH-1:0] gma_read_data_in,
  input  logic                  gma_pronto_in,
  output logic                  caminho_valid_out,
  input  logic                  caminho_ready_in,
  output logic [ADDR_WIDTH-1:0] caminho_data_out,
  output logic                  caminho_last_out,
  output logic                  ocupado_out,
  output logic [1:0]            erro_out
);

  localparam int CW = $clog2(MAX_CAMINHO + 1);
  localparam int IW = (MAX_CAMINHO > 1) ? $clog2(MAX_CAMINHO) : 1;
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_CAMINHO);
  localparam logic [TW-1:0] TMO     = TW'(TIMEOUT_CICLOS);

  typedef enum logic [2:0] {
    OCIOSO,
    INICIAR,
    COLETAR,
    ENVIAR,
    ERRO
  } estado_t;

  estado_t               state_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         idx_q;
  logic [TW-1:0]         tmr_q;
  logic                  rdy_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic                  wr_data_q;
  logic                  inic_q;
  logic [ADDR_WIDTH-1:0] fonte_q;
  logic [ADDR_WIDTH-1:0] destino_q;
  logic                  val_q;
  logic [ADDR_WIDTH-1:0] data_q;
  logic                  last_q;
  logic                  ocup_q;
  logic [1:0]            erro_q;

  logic [ADDR_WIDTH-1:0] buf_q [MAX_CAMINHO];

  logic                  strobe;
  logic                  e_fonte;
  logic                  hs;
  logic [CW-1:0]         cnt_inc;
  logic [TW-1:0]         tmr_inc;

  logic [ADDR_WIDTH-1:0] first_data;
  logic [CW-1:0]         first_idx;
  logic                  first_last;
  logic [CW-1:0]         nxt_idx;
  logic                  nxt_last;
  logic [ADDR_WIDTH-1:0] nxt_data;

  assign strobe  = (state_q == COLETAR) & gma_pronto_in;
  assign e_fonte = (gma_read_data_in == fonte_q);
  assign hs      = val_q & caminho_ready_in;
  assign cnt_inc = cnt_q + CW'(1);
  assign tmr_inc = tmr_q + TW'(1);

  // Replay order: first node is loaded on the matching strobe itself
  always_comb begin
    first_data = gma_read_data_in;
    first_idx  = '0;
    first_last = (cnt_q == '0);
    nxt_idx    = '0;
    nxt_last   = 1'b0;
`ifdef CAMINHO_REVERSO_EN
    first_data = gma_read_data_in;
    first_idx  = cnt_q;
    nxt_idx    = idx_q - CW'(1);
    nxt_last   = (nxt_idx == '0);
`else
    first_data = (cnt_q == '0) ? gma_read_data_in : buf_q[0];
    first_idx  = '0;
    nxt_idx    = idx_q + CW'(1);
    nxt_last   = (nxt_idx == cnt_q - CW'(1));
`endif
    nxt_data   = buf_q[nxt_idx[IW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (strobe) begin
      buf_q[cnt_q[IW-1:0]] <= gma_read_data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= OCIOSO;
      cnt_q     <= '0;
      idx_q     <= '0;
      tmr_q     <= '0;
      rdy_q     <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 1'b0;
      inic_q    <= 1'b0;
      fonte_q   <= '0;
      destino_q <= '0;
      val_q     <= 1'b0;
      data_q    <= '0;
      last_q    <= 1'b0;
      ocup_q    <= 1'b0;
      erro_q    <= 2'b00;
    end else begin
      wr_en_q <= 1'b0;
      inic_q  <= 1'b0;
      unique case (state_q)
        OCIOSO: begin
          if (cmd_valid_in) begin
            if (!cmd_tipo_in) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= cmd_addr_a_in;
              wr_data_q <= cmd_obst_in;
            end else begin
              fonte_q   <= cmd_addr_a_in;
              destino_q <= cmd_addr_b_in;
              erro_q    <= 2'b00;
              inic_q    <= 1'b1;
              rdy_q     <= 1'b0;
              ocup_q    <= 1'b1;
              state_q   <= INICIAR;
            end
          end
        end
        INICIAR: begin
          cnt_q   <= '0;
          tmr_q   <= '0;
          state_q <= COLETAR;
        end
        COLETAR: begin
          if (gma_pronto_in) begin
            cnt_q <= cnt_inc;
            tmr_q <= '0;
            if (e_fonte) begin
              val_q   <= 1'b1;
              data_q  <= first_data;
              last_q  <= first_last;
              idx_q   <= first_idx;
              state_q <= ENVIAR;
            end else if (cnt_inc == CNT_MAX) begin
              erro_q  <= 2'b10;
              state_q <= ERRO;
            end
          end else begin
            if (tmr_q != TMO) begin
              tmr_q <= tmr_inc;
            end
            if (tmr_inc >= TMO) begin
              erro_q  <= 2'b01;
              state_q <= ERRO;
            end
          end
        end
        ENVIAR: begin
          if (hs) begin
            if (last_q) begin
              val_q   <= 1'b0;
              last_q  <= 1'b0;
              rdy_q   <= 1'b1;
              ocup_q  <= 1'b0;
              state_q <= OCIOSO;
            end else begin
              data_q <= nxt_data;
              last_q <= nxt_last;
              idx_q  <= nxt_idx;
            end
          end
        end
        ERRO: begin
          rdy_q   <= 1'b1;
          ocup_q  <= 1'b0;
          state_q <= OCIOSO;
        end
        default: begin
          rdy_q   <= 1'b1;
          ocup_q  <= 1'b0;
          val_q   <= 1'b0;
          state_q <= OCIOSO;
        end
      endcase
    end
  end

  assign cmd_ready_out            = rdy_q;
  assign obstaculos_wr_enable_out = wr_en_q;
  assign obstaculos_wr_addr_out   = wr_addr_q;
  assign obstaculos_wr_data_out   = wr_data_q;
  assign top_wr_fonte_out         = inic_q;
  assign top_addr_fonte_out       = fonte_q;
  assign top_addr_destino_out     = destino_q;
  assign caminho_valid_out        = val_q;
  assign caminho_data_out         = data_q;
  assign caminho_last_out         = last_q;
  assign ocupado_out              = ocup_q;
  assign erro_out                 = erro_q;

endmodule

// File: tb/tb_sequenciador_caminho_host.sv
// Bench for sequenciador_caminho_host: directed scenarios checked
// against a queue-based path model and hand-computed literals.
module tb_sequenciador_caminho_host;

  localparam int AW   = 8;
  localparam int MAXC = 4;
  localparam int TMO  = 100;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid_in;
  logic          cmd_ready_out;
  logic          cmd_tipo_in;
  logic [AW-1:0] cmd_addr_a_in;
  logic [AW-1:0] cmd_addr_b_in;
  logic          cmd_obst_in;
  logic          obst_we;
  logic [AW-1:0] obst_wa;
  logic          obst_wd;
  logic          fonte_p;
  logic [AW-1:0] a_fonte;
  logic [AW-1:0] a_dest;
  logic [AW-1:0] gma_data;
  logic          gma_pronto;
  logic          c_valid;
  logic          c_ready;
  logic [AW-1:0] c_data;
  logic          c_last;
  logic          ocupado;
  logic [1:0]    erro;

  sequenciador_caminho_host #(
    .ADDR_WIDTH    (AW),
    .MAX_CAMINHO   (MAXC),
    .TIMEOUT_CICLOS(TMO)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .cmd_valid_in            (cmd_valid_in),
    .cmd_ready_out           (cmd_ready_out),
    .cmd_tipo_in             (cmd_tipo_in),
    .cmd_addr_a_in           (cmd_addr_a_in),
    .cmd_addr_b_in           (cmd_addr_b_in),
    .cmd_obst_in             (cmd_obst_in),
    .obstaculos_wr_enable_out(obst_we),
    .obstaculos_wr_addr_out  (obst_wa),
    .obstaculos_wr_data_out  (obst_wd),
    .top_wr_fonte_out        (fonte_p),
    .top_addr_fonte_out      (a_fonte),
    .top_addr_destino_out    (a_dest),
    .gma_read_data_in        (gma_data),
    .gma_pronto_in           (gma_pronto),
    .caminho_valid_out       (c_valid),
    .caminho_ready_in        (c_ready),
    .caminho_data_out        (c_data),
    .caminho_last_out        (c_last),
    .ocupado_out             (ocupado),
    .erro_out                (erro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] recv[$];
  bit            exp_wr;
  logic [AW-1:0] exp_wa;
  logic          exp_wd;
  bit            exp_st;
  logic [AW-1:0] m_src;
  logic [AW-1:0] m_dst;
  int            wr_pulses;

  initial begin
    exp_wr = 0; exp_st = 0; m_src = '0; m_dst = '0; wr_pulses = 0;
  end

  // Cycle compare; handshakes/accepts are predicted here for the next edge
  always @(negedge clk) begin
    if (rst_n) begin
      chk("wr_en", obst_we, exp_wr);
      if (exp_wr) begin
        chk("wr_addr", obst_wa, exp_wa);
        chk("wr_data", obst_wd, exp_wd);
      end
      if (obst_we) wr_pulses++;
      chk("fonte_pulse", fonte_p, exp_st);
      if (exp_st) chk("erro_clr", erro, 0);
      chk("addr_fonte", a_fonte, m_src);
      chk("addr_dest", a_dest, m_dst);
      exp_wr = 0;
      exp_st = 0;
      if (cmd_valid_in && cmd_ready_out) begin
        if (!cmd_tipo_in) begin
          exp_wr = 1; exp_wa = cmd_addr_a_in; exp_wd = cmd_obst_in;
        end else begin
          exp_st = 1; m_src = cmd_addr_a_in; m_dst = cmd_addr_b_in;
        end
      end
      if (c_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          chk("path_data", c_data, exp_q[0]);
          chk("path_last", c_last, exp_q.size() == 1);
          if (c_ready) begin
            recv.push_back(c_data);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(bit t, int a, int b, bit o);
    int n;
    n = 0;
    cmd_valid_in  = 1'b1;
    cmd_tipo_in   = t;
    cmd_addr_a_in = AW'(a);
    cmd_addr_b_in = AW'(b);
    cmd_obst_in   = o;
    while (!cmd_ready_out && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("cmd_accept_timeout", 1, 0);
    tick();
    cmd_valid_in = 1'b0;
  endtask

  task automatic strobe(int v);
    gma_data   = AW'(v);
    gma_pronto = 1'b1;
    tick();
    gma_pronto = 1'b0;
  endtask

  // Start a search and feed the strobes; expected replay follows from the rules
  task automatic run_path(int src, int dst, int n,
                          int s0, int s1, int s2, int s3, int gap);
    int s[4];
    logic [AW-1:0] p[$];
    bit hit;
    s = '{s0, s1, s2, s3};
    hit = 0;
    recv.delete();
    for (int i = 0; i < n; i++) begin
      p.push_back(AW'(s[i]));
      if (s[i] == src) begin
        hit = 1;
        break;
      end
    end
`ifdef CAMINHO_REVERSO_EN
    for (int i = p.size() - 1; i >= 0; i--) exp_q.push_back(p[i]);
`else
    for (int i = 0; i < p.size(); i++) exp_q.push_back(p[i]);
`endif
    send_cmd(1, src, dst, 0);
    tick();
    repeat (gap) tick();
    for (int i = 0; i < p.size(); i++) strobe(int'(p[i]));
    if (hit) chk("first_valid_latency", c_valid, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((ocupado || exp_q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("idle_timeout", 1, 0);
    chk("idle_ready", cmd_ready_out, 1);
    chk("idle_ocupado", ocupado, 0);
  endtask

  task automatic chk_recv(string nm, int n, int e0, int e1, int e2, int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    chk({nm, "_len"}, recv.size(), n);
    for (int i = 0; i < n && i < recv.size(); i++) chk(nm, recv[i], e[i]);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", cmd_ready_out, 1);
    chk("rst_wr_en", obst_we, 0);
    chk("rst_wr_addr", obst_wa, 0);
    chk("rst_wr_data", obst_wd, 0);
    chk("rst_fonte", fonte_p, 0);
    chk("rst_addr_fonte", a_fonte, 0);
    chk("rst_addr_dest", a_dest, 0);
    chk("rst_valid", c_valid, 0);
    chk("rst_data", c_data, 0);
    chk("rst_last", c_last, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_erro", erro, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    cmd_valid_in = 1'b0; cmd_tipo_in = 1'b0; cmd_obst_in = 1'b0;
    cmd_addr_a_in = '0; cmd_addr_b_in = '0;
    gma_data = '0; gma_pronto = 1'b0; c_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Back-to-back obstacle writes
    send_cmd(0, 5, 0, 1);
    send_cmd(0, 6, 0, 1);
    send_cmd(0, 7, 0, 0);
    tick();
    tick();
    chk("wr_pulse_count", wr_pulses, 3);

    // Source 3, destination 9, strobes 9 8 3
    c_ready = 1'b1;
    run_path(3, 9, 3, 9, 8, 3, 0, 0);
    wait_idle();
`ifdef CAMINHO_REVERSO_EN
    chk_recv("path_3_9", 3, 3, 8, 9, 0);
`else
    chk_recv("path_3_9", 3, 9, 8, 3, 0);
`endif
    chk("erro_ok", erro, 0);

    // Source equals destination
    run_path(4, 4, 1, 4, 0, 0, 0, 0);
    wait_idle();
    chk_recv("path_4_4", 1, 4, 0, 0, 0);

    // Full buffer ending on source, host stalls 10 cycles mid-path
    c_ready = 1'b0;
    run_path(1, 2, 4, 2, 7, 6, 1, 0);
    tick();
    c_ready = 1'b1;
    tick();
    c_ready = 1'b0;
    repeat (10) tick();
    chk("stall_valid_held", c_valid, 1);
    c_ready = 1'b1;
    wait_idle();
`ifdef CAMINHO_REVERSO_EN
    chk_recv("path_stall", 4, 1, 6, 7, 2);
`else
    chk_recv("path_stall", 4, 2, 7, 6, 1);
`endif

    // Timeout: no strobe for TMO cycles of collection
    send_cmd(1, 5, 6, 0);
    repeat (TMO) tick();
    chk("tmo_last_coletar_busy", ocupado, 1);
    chk("tmo_not_yet", erro, 0);
    tick();
    chk("tmo_erro", erro, 2'b01);
    chk("tmo_busy_in_erro", ocupado, 1);
    tick();
    chk("tmo_idle", ocupado, 0);
    chk("tmo_erro_sticky", erro, 2'b01);
    chk("tmo_ready", cmd_ready_out, 1);

    // Next start clears error; strobe on the last cycle before timeout
    run_path(5, 5, 1, 5, 0, 0, 0, TMO - 1);
    wait_idle();
    chk_recv("path_late", 1, 5, 0, 0, 0);
    chk("late_erro", erro, 0);

    // Overflow
    send_cmd(1, 0, 1, 0);
    tick();
    strobe(10);
    strobe(11);
    strobe(12);
    strobe(13);
    chk("ovf_erro", erro, 2'b10);
    chk("ovf_no_valid", c_valid, 0);
    chk("ovf_busy", ocupado, 1);
    tick();
    chk("ovf_idle", ocupado, 0);
    chk("ovf_erro_sticky", erro, 2'b10);

    // Reset during replay
    c_ready = 1'b0;
    run_path(3, 9, 3, 9, 8, 3, 0, 0);
    tick();
    chk("pre_rst_valid", c_valid, 1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    recv.delete();
    exp_wr = 0; exp_st = 0; m_src = '0; m_dst = '0;
    @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    c_ready = 1'b1;
    tick();
    send_cmd(0, 8, 0, 1);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
